// File: rtl/lowpass_pkg.sv
// Shared types, default 3 kHz Butterworth coefficients (fs = 24 kHz, Q2.14)
// and the 16-bit saturation helper for the low-pass biquad.
package lowpass_pkg;

  typedef logic signed [15:0] sample_t;
  typedef logic signed [31:0] acc_t;

  localparam int      FRAC_BITS = 14;
  localparam sample_t B0_DEF    = 16'sd1600;
  localparam sample_t B1_DEF    = 16'sd3199;
  localparam sample_t B2_DEF    = 16'sd1600;
  localparam sample_t A1_DEF    = -16'sd15447;
  localparam sample_t A2_DEF    = 16'sd5461;

  function automatic sample_t saturate16(input acc_t v);
    if (v > acc_t'(32767)) begin
      return 16'sd32767;
    end else if (v < -acc_t'(32768)) begin
      return -16'sd32768;
    end else begin
      return v[15:0];
    end
  endfunction

endpackage

// File: rtl/lowpass_if.sv
// Sample-stream bundle for the low-pass filter: input sample, filtered output
// and the three bring-up debug taps.
interface lowpass_if;
  import lowpass_pkg::*;

  sample_t lowpassIn;
  sample_t lowpassOut;
  acc_t    lowpassOut2;
  sample_t lowpassOut3;
  acc_t    lowpassOut4;

  modport master (
    output lowpassIn,
    input  lowpassOut, lowpassOut2, lowpassOut3, lowpassOut4
  );

  modport slave (
    input  lowpassIn,
    output lowpassOut, lowpassOut2, lowpassOut3, lowpassOut4
  );

endinterface

// File: rtl/lowpass_filter_biquad_df1.sv
// Generic direct-form-I biquad: one sample per clock, 32-bit accumulator,
// floor scaling and saturation applied before the output is fed back.
module biquad_df1
  import lowpass_pkg::*;
#(
  parameter sample_t B0   = B0_DEF,
  parameter sample_t B1   = B1_DEF,
  parameter sample_t B2   = B2_DEF,
  parameter sample_t A1   = A1_DEF,
  parameter sample_t A2   = A2_DEF,
  parameter int      FRAC = FRAC_BITS
) (
  input  logic    clk,
  input  logic    reset_n,
  input  sample_t x,
  output sample_t y,
  output acc_t    acc_dbg,
  output sample_t x1_dbg,
  output acc_t    fb_dbg
);

  sample_t x1, x2, y1, y2;
  acc_t    acc_q, fb_q;
  acc_t    ff, fb, acc;
  sample_t y_next;

  always_comb begin
    ff     = acc_t'(B0) * acc_t'(x) + acc_t'(B1) * acc_t'(x1) + acc_t'(B2) * acc_t'(x2);
    fb     = acc_t'(A1) * acc_t'(y1) + acc_t'(A2) * acc_t'(y2);
    acc    = ff - fb;
    // Arithmetic shift floors toward -inf; clamp before the value re-enters the loop.
    y_next = saturate16(acc >>> FRAC);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x1    <= '0;
      x2    <= '0;
      y1    <= '0;
      y2    <= '0;
      acc_q <= '0;
      fb_q  <= '0;
    end else begin
      x1    <= x;
      x2    <= x1;
      y1    <= y_next;
      y2    <= y1;
      acc_q <= acc;
      fb_q  <= fb;
    end
  end

  assign y       = y1;
  assign acc_dbg = acc_q;
  assign x1_dbg  = x1;
  assign fb_dbg  = fb_q;

endmodule

// File: rtl/lowpass_filter.sv
// Audio channel-strip low-pass: thin wrapper binding the 3 kHz coefficient
// set to the generic biquad datapath.
module lowpass_filter
  import lowpass_pkg::*;
#(
  parameter sample_t B0 = B0_DEF,
  parameter sample_t B1 = B1_DEF,
  parameter sample_t B2 = B2_DEF,
  parameter sample_t A1 = A1_DEF,
  parameter sample_t A2 = A2_DEF,
  parameter int      FB = FRAC_BITS
) (
  input logic      clk,
  input logic      reset_n,
  lowpass_if.slave bus
);

  biquad_df1 #(
    .B0   (B0),
    .B1   (B1),
    .B2   (B2),
    .A1   (A1),
    .A2   (A2),
    .FRAC (FB)
  ) u_biquad (
    .clk     (clk),
    .reset_n (reset_n),
    .x       (bus.lowpassIn),
    .y       (bus.lowpassOut),
    .acc_dbg (bus.lowpassOut2),
    .x1_dbg  (bus.lowpassOut3),
    .fb_dbg  (bus.lowpassOut4)
  );

endmodule

// File: tb/tb_lowpass_filter.sv
// Directed-vector bench for lowpass_filter: reset, step edges, saturation,
// Nyquist rejection, cutoff gain and asynchronous mid-stream reset.
module tb_lowpass_filter;
  import lowpass_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  lowpass_if bus ();

  lowpass_filter dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] got,
                     input logic signed [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input sample_t v);
    @(negedge clk);
    bus.lowpassIn = v;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_out"},  bus.lowpassOut,  0);
    chk({tag, "_out2"}, bus.lowpassOut2, 0);
    chk({tag, "_out3"}, bus.lowpassOut3, 0);
    chk({tag, "_out4"}, bus.lowpassOut4, 0);
  endtask

  // Applies reset at a negedge, releases it a cycle later with the next sample set up.
  task automatic pulse_reset(input sample_t first);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    bus.lowpassIn = first;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_step_start(input string tag);
    chk({tag, "_e1_out2"}, bus.lowpassOut2, 52427200);
    chk({tag, "_e1_out"},  bus.lowpassOut,  3199);
    chk({tag, "_e1_out3"}, bus.lowpassOut3, 32767);
    chk({tag, "_e1_out4"}, bus.lowpassOut4, 0);
    drive(16'sd32767);
    chk({tag, "_e2_out2"}, bus.lowpassOut2, 206663786);
    chk({tag, "_e2_out"},  bus.lowpassOut,  12613);
    chk({tag, "_e2_out3"}, bus.lowpassOut3, 32767);
    chk({tag, "_e2_out4"}, bus.lowpassOut4, -49414953);
  endtask

  sample_t sine_tab [8];

  initial begin
    int      ymin, ymax, amax;
    sample_t yv;

    sine_tab = '{16'sd0, 16'sd23170, 16'sd32767, 16'sd23170,
                 16'sd0, -16'sd23170, -16'sd32767, -16'sd23170};

    // Held in reset with a full-scale input: everything stays cleared.
    reset_n = 1'b0;
    bus.lowpassIn = 16'sd32767;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("rst_hold");

    // Positive step from reset.
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk_step_start("pstep");
    ymin = 32767;
    ymax = -32768;
    for (int i = 0; i < 60; i++) begin
      drive(16'sd32767);
      yv = bus.lowpassOut;
      if (int'(yv) < ymin) ymin = int'(yv);
      if (int'(yv) > ymax) ymax = int'(yv);
    end
    chk("pstep_no_wrap", (ymin >= 0) ? 1 : 0, 1);
    chk("pstep_clip_max", ymax, 32767);
    chk("pstep_final_out", bus.lowpassOut, 32767);
    chk("pstep_final_acc", bus.lowpassOut2, 536887295);
    chk("pstep_final_fb", bus.lowpassOut4, -327211262);

    // Negative full-scale step.
    pulse_reset(-16'sd32768);
    chk("nstep_e1_out", bus.lowpassOut, -3200);
    ymax = -32768;
    for (int i = 0; i < 60; i++) begin
      drive(-16'sd32768);
      yv = bus.lowpassOut;
      if (int'(yv) > ymax) ymax = int'(yv);
    end
    chk("nstep_no_wrap", (ymax <= 0) ? 1 : 0, 1);
    chk("nstep_final_out", bus.lowpassOut, -32768);
    chk("nstep_final_acc", bus.lowpassOut2, -536903680);

    // Nyquist-rate alternation is strongly rejected.
    pulse_reset(16'sd32767);
    amax = 0;
    for (int i = 1; i < 80; i++) begin
      drive((i % 2 == 0) ? 16'sd32767 : -16'sd32768);
      yv = bus.lowpassOut;
      if (i >= 50) begin
        if (int'(yv) > amax) amax = int'(yv);
        if (-int'(yv) > amax) amax = -int'(yv);
      end
    end
    chk("nyq_amp_lt_1000", (amax < 1000) ? 1 : 0, 1);
    chk("nyq_x1_tap", bus.lowpassOut3, -32768);

    // 3 kHz sine at the cutoff: steady peak near 23170 (-3 dB).
    pulse_reset(sine_tab[0]);
    ymin = 32767;
    ymax = -32768;
    for (int i = 1; i < 96; i++) begin
      drive(sine_tab[i % 8]);
      yv = bus.lowpassOut;
      if (i >= 64) begin
        if (int'(yv) < ymin) ymin = int'(yv);
        if (int'(yv) > ymax) ymax = int'(yv);
      end
    end
    chk("sine_peak_pos", (ymax >= 22707 && ymax <= 23633) ? 1 : 0, 1);
    chk("sine_peak_neg", (ymin <= -22707 && ymin >= -23633) ? 1 : 0, 1);

    // Mid-stream asynchronous reset: outputs clear with no clock edge.
    for (int i = 0; i < 5; i++) drive(sine_tab[i % 8]);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk_zero("rst_async");
    @(posedge clk);
    #1;
    chk_zero("rst_async_edge");
    @(negedge clk);
    bus.lowpassIn = 16'sd32767;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk_step_start("restep");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
